uart_rx_byte: RTL and testbench

- Oversampling UART receiver running directly on the 100 MHz `clk`, replacing slow-clock bit sampling with counter-timed mid-bit sampling.
- Sits between the `UART_RX` pin and the byte consumer (LED/command logic).
- Synchronises the line, validates the start bit and assembles 8N1 frames, LSB first.
- Presents each good byte through a valid/ready holding register, with frame-error and overrun pulses.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx_byte.sv | 133 +++++++++++++
 tb/tb_uart_rx_byte.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path and its consumers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  localparam int UART_CLKS_PER_BIT_115200 = 868;
  localparam int UART_DATA_BITS           = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs (serial line, buttons).
// Latency: 2 clk cycles. Backpressure: none, free-running.
// Reset value is a parameter so an idle-high line never reads as a spurious edge.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with counter-timed mid-bit sampling and a one-byte valid/ready holding register.
// Latency: byte valid the cycle after the stop-bit sample (~9.5 bit times after start detect).
// Backpressure: a full holding register drops the new byte and pulses overrun; the line is never stalled.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_error,
  output logic                      overrun,
  output logic                      busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_rx_state_t            state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_LAST)
              state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              // A same-cycle handshake frees the register, so the new byte still lands.
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clk/bit with a byte scoreboard checked on every handshake.
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int fe_cnt = 0;
  int ovr_cnt = 0;
  int valid_rise_cyc = -1;
  logic prev_valid = 1'b0;
  logic busy_seen = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL sb_underflow: observed byte %02h expected none", rx_data);
        end
      end else begin
        check("sb_byte", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
    if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = rx_valid;
    if (rx_valid)    valid_cnt++;
    if (frame_error) fe_cnt++;
    if (overrun)     ovr_cnt++;
    if (busy)        busy_seen = 1'b1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives ncyc cycles of an 8N1 frame; ready_at >= 0 pulses rx_ready at that cycle offset.
  task automatic send_frame(input logic [7:0] b, input int ready_at, input int ncyc);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      rx = fr[c / CPB];
      if (ready_at >= 0) rx_ready = (c == ready_at);
      tick(1);
    end
    if (ready_at >= 0) rx_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},  32'(rx_data),     32'h0);
    check({tag, "_valid"}, 32'(rx_valid),    32'h0);
    check({tag, "_fe"},    32'(frame_error), 32'h0);
    check({tag, "_ovr"},   32'(overrun),     32'h0);
    check({tag, "_busy"},  32'(busy),        32'h0);
  endtask

  int t_start;
  int v0, f0, o0;

  initial begin
    reset    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    check_reset_vals("rst");
    reset = 1'b1;
    tick(5);

    // Good frame: latency and single-cycle valid.
    v0 = valid_cnt; f0 = fe_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'hA5);
    t_start = cyc;
    send_frame(8'hA5, -1, 10 * CPB);
    tick(4);
    check("good_latency", 32'(valid_rise_cyc - t_start), 32'd155);
    check("good_valid_cycles", 32'(valid_cnt - v0), 32'd1);
    check("good_fe", 32'(fe_cnt - f0), 32'd0);
    check("good_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("good_busy_idle", 32'(busy), 32'd0);

    // Glitch: short low pulse is rejected at the start-bit sample.
    v0 = valid_cnt; f0 = fe_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy_idle", 32'(busy), 32'd0);
    check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_fe", 32'(fe_cnt - f0), 32'd0);

    // Break: line held low for 20 bit times.
    v0 = valid_cnt; f0 = fe_cnt;
    rx = 1'b0;
    tick(20 * CPB);
    check("break_busy_held", 32'(busy), 32'd1);
    rx = 1'b1;
    tick(6);
    check("break_busy_idle", 32'(busy), 32'd0);
    check("break_fe", 32'(fe_cnt - f0), 32'd1);
    check("break_valid", 32'(valid_cnt - v0), 32'd0);
    tick(2 * CPB);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, -1, 10 * CPB);
    tick(4);
    check("after_break_valid", 32'(valid_cnt - v0), 32'd1);

    // Overrun: second byte arrives while the first is still held.
    rx_ready = 1'b0;
    o0 = ovr_cnt; f0 = fe_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, -1, 10 * CPB);
    send_frame(8'h22, -1, 10 * CPB);
    tick(4);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_fe", 32'(fe_cnt - f0), 32'd0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("ovr_drained", 32'(rx_valid), 32'd0);

    // Handshake in the same cycle as the second byte's stop sample.
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, -1, 10 * CPB);
    send_frame(8'h22, 154, 10 * CPB);
    tick(4);
    check("simul_data", 32'(rx_data), 32'h22);
    check("simul_valid", 32'(rx_valid), 32'd1);
    check("simul_ovr", 32'(ovr_cnt - o0), 32'd0);
    rx_ready = 1'b1;
    tick(1);
    check("simul_drained", 32'(rx_valid), 32'd0);

    // Reset mid-frame during bit 4 of 0xFF.
    v0 = valid_cnt;
    send_frame(8'hFF, -1, 5 * CPB + CPB / 2);
    reset = 1'b0;
    rx    = 1'b1;
    tick(3);
    check_reset_vals("midrst");
    reset = 1'b1;
    tick(10 * CPB);
    check("midrst_no_byte", 32'(valid_cnt - v0), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, -1, 10 * CPB);
    tick(4);
    check("post_rst_valid", 32'(valid_cnt - v0), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
